// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: multi-cycle sequencer for the 4-bit ALU datapath.
// Fetches 16-bit instructions {op, rd, rs1, rs2_imm} from a combinational
// instruction memory, walks each one through FETCH/DECODE/READ/EXEC/WB,
// drives the ALU opcode and commits results to the register file.
// Optional feature macro: FLOW_TRAP_EN -- when defined, an ALU flow error
// in WB parks the sequencer in TRAP instead of continuing with the next
// instruction.
module alu_seq_ctrl #(
  parameter int PC_W     = 4,
  parameter int PROG_LEN = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [15:0]     instr,
  output logic [PC_W-1:0] imem_addr,
  output logic [2:0]      pst,
  output logic [3:0]      ALU_Op,
  output logic [3:0]      rd1_addr,
  output logic [3:0]      rd2_addr,
  output logic [3:0]      imm,
  output logic            imm_sel,
  output logic            wr_en,
  output logic [3:0]      wr_addr,
  input  logic            flowcheck,
  input  logic            overflow,
  input  logic            underflow,
  output logic            busy,
  output logic            done,
  output logic            flow_err,
  output logic            trap
);

  // State encoding is exported unchanged on pst for the ALU.
  localparam logic [2:0] S_IDLE   = 3'b000;
  localparam logic [2:0] S_FETCH  = 3'b001;
  localparam logic [2:0] S_DECODE = 3'b010;
  localparam logic [2:0] S_READ   = 3'b011;
  localparam logic [2:0] S_EXEC   = 3'b100;
  localparam logic [2:0] S_WB     = 3'b101;
  localparam logic [2:0] S_DONE   = 3'b110;
  localparam logic [2:0] S_TRAP   = 3'b111;

  localparam logic [3:0] OP_NOP   = 4'b0000;
  localparam logic [3:0] OP_WRITE = 4'b0001;
  localparam logic [3:0] OP_READ  = 4'b0010;
  localparam logic [3:0] OP_ADDI  = 4'b1100;
  localparam logic [3:0] OP_SUBI  = 4'b1101;

  localparam logic [PC_W-1:0] LAST_PC = PC_W'(PROG_LEN - 1);

  logic [2:0]      state_q, state_d;
  logic [PC_W-1:0] pc_q;
  logic [15:0]     ir_q;
  logic [3:0]      alu_op_q;
  logic [3:0]      rd1_q, rd2_q, imm_q, wr_addr_q;
  logic            imm_sel_q;
  logic            wr_cand_q;
  logic            flow_err_q;
  logic            armed_q;
  logic            run_start;
  logic            flow_fault;
  logic [3:0]      ir_op;

  // overflow/underflow are already summarised by flowcheck; kept on the
  // port list for the ALU's benefit and deliberately not decoded here.
  logic unused_flags;
  assign unused_flags = overflow ^ underflow;

  assign ir_op      = ir_q[15:12];
  assign flow_fault = (state_q == S_WB) && flowcheck;
  // A run begins from IDLE, or from TRAP when restarted by start.
  assign run_start  = (state_d == S_FETCH) &&
                      ((state_q == S_IDLE) || (state_q == S_TRAP));

  // Next-state decode.
  always_comb begin
    // NOTE: default assignment first so no path leaves state_d unassigned,
    // which would otherwise infer a latch.
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start && armed_q) state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: state_d = S_READ;
      S_READ:   state_d = S_EXEC;
      S_EXEC:   state_d = S_WB;
      S_WB: begin
`ifdef FLOW_TRAP_EN
        if (flowcheck)              state_d = S_TRAP;
        else if (pc_q < LAST_PC)    state_d = S_FETCH;
        else                        state_d = S_DONE;
`else
        if (pc_q < LAST_PC)         state_d = S_FETCH;
        else                        state_d = S_DONE;
`endif
      end
      S_DONE:   state_d = S_IDLE;
      S_TRAP: begin
`ifdef FLOW_TRAP_EN
        if (start) state_d = S_FETCH;
`else
        state_d = S_IDLE;
`endif
      end
      default:  state_d = S_IDLE;
    endcase
  end

  // State register; armed_q blocks a start that coincides with the
  // reset-release cycle.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    if (!rst) begin
      state_q <= S_IDLE;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      armed_q <= 1'b1;
    end
  end

  // Program counter and sticky flow-error flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q       <= '0;
      flow_err_q <= 1'b0;
    end else begin
      if (run_start)
        pc_q <= '0;
      else if ((state_q == S_WB) && (state_d == S_FETCH))
        pc_q <= pc_q + PC_W'(1);

      if (run_start)
        flow_err_q <= 1'b0;
      else if (flow_fault)
        flow_err_q <= 1'b1;
    end
  end

  // Instruction register and decoded register-file / immediate fields.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ir_q      <= '0;
      rd1_q     <= '0;
      rd2_q     <= '0;
      imm_q     <= '0;
      wr_addr_q <= '0;
      imm_sel_q <= 1'b0;
    end else begin
      if (state_q == S_FETCH)
        ir_q <= instr;
      if (state_q == S_DECODE) begin
        rd1_q     <= ir_q[7:4];
        rd2_q     <= ir_q[3:0];
        imm_q     <= ir_q[3:0];
        wr_addr_q <= ir_q[11:8];
        imm_sel_q <= (ir_op == OP_WRITE) || (ir_op == OP_ADDI) ||
                     (ir_op == OP_SUBI);
      end
    end
  end

  // Opcode and write candidate, registered on entry to EXEC / WB so both
  // are clean for exactly one state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alu_op_q  <= OP_NOP;
      wr_cand_q <= 1'b0;
    end else begin
      alu_op_q  <= (state_d == S_EXEC) ? ir_op : OP_NOP;
      wr_cand_q <= (state_d == S_WB) && (ir_op != OP_NOP) && (ir_op != OP_READ);
    end
  end

  // flowcheck only becomes valid during WB, so the write strobe has to be
  // vetoed combinationally in that same cycle.
  assign wr_en     = wr_cand_q & ~flowcheck;

  assign pst       = state_q;
  assign imem_addr = pc_q;
  assign ALU_Op    = alu_op_q;
  assign rd1_addr  = rd1_q;
  assign rd2_addr  = rd2_q;
  assign imm       = imm_q;
  assign imm_sel   = imm_sel_q;
  assign wr_addr   = wr_addr_q;
  assign flow_err  = flow_err_q;
  assign busy      = (state_q >= S_FETCH) && (state_q <= S_WB);
  assign done      = (state_q == S_DONE);
  assign trap      = (state_q == S_TRAP);

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl: one instance with PROG_LEN=1 and one
// with PROG_LEN=16, each fed by its own small instruction memory.
module tb_alu_seq_ctrl;

  logic clk = 1'b0;
  logic rst;

  logic        start_a, start_b;
  logic        fc_en_a, fc_en_b;
  logic [15:0] mem_a [16];
  logic [15:0] mem_b [16];

  logic [3:0]  imem_addr_a, imem_addr_b;
  logic [2:0]  pst_a, pst_b;
  logic [3:0]  alu_op_a, alu_op_b;
  logic [3:0]  rd1_a, rd1_b, rd2_a, rd2_b, imm_a, imm_b, wr_addr_a, wr_addr_b;
  logic        imm_sel_a, imm_sel_b, wr_en_a, wr_en_b;
  logic        busy_a, busy_b, done_a, done_b, flow_err_a, flow_err_b;
  logic        trap_a, trap_b;
  logic        flowcheck_a, flowcheck_b;
  logic [15:0] instr_a, instr_b;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  assign instr_a     = mem_a[imem_addr_a];
  assign instr_b     = mem_b[imem_addr_b];
  // The ALU model raises flowcheck only while the sequencer is in WB.
  assign flowcheck_a = fc_en_a && (pst_a == 3'b101);
  assign flowcheck_b = fc_en_b && (pst_b == 3'b101);

  alu_seq_ctrl #(.PC_W(4), .PROG_LEN(1)) u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .instr(instr_a),
    .imem_addr(imem_addr_a), .pst(pst_a), .ALU_Op(alu_op_a),
    .rd1_addr(rd1_a), .rd2_addr(rd2_a), .imm(imm_a), .imm_sel(imm_sel_a),
    .wr_en(wr_en_a), .wr_addr(wr_addr_a), .flowcheck(flowcheck_a),
    .overflow(1'b0), .underflow(1'b0), .busy(busy_a), .done(done_a),
    .flow_err(flow_err_a), .trap(trap_a)
  );

  alu_seq_ctrl #(.PC_W(4), .PROG_LEN(16)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .instr(instr_b),
    .imem_addr(imem_addr_b), .pst(pst_b), .ALU_Op(alu_op_b),
    .rd1_addr(rd1_b), .rd2_addr(rd2_b), .imm(imm_b), .imm_sel(imm_sel_b),
    .wr_en(wr_en_b), .wr_addr(wr_addr_b), .flowcheck(flowcheck_b),
    .overflow(1'b0), .underflow(1'b0), .busy(busy_b), .done(done_b),
    .flow_err(flow_err_b), .trap(trap_b)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Global time guard: a hung run still reports before stopping.
  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] exp_seq [7];
    logic [3:0] exp_pc;
    logic       exp_ferr;
    logic       got_done;
    int         done_idx, fetch_k, wr_seen, idx;

    exp_seq = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd0};
    for (int i = 0; i < 16; i++) begin
      mem_a[i] = 16'h0000;
      mem_b[i] = 16'h0000;
    end
    fc_en_a = 1'b0;
    fc_en_b = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    rst     = 1'b0;

    // Reset held with random start: everything stays at reset values.
    for (int c = 0; c < 4; c++) begin
      start_a = 1'($urandom_range(0, 1));
      start_b = 1'($urandom_range(0, 1));
      tick();
      check("rst_pst_a", 32'(pst_a), 0);
      check("rst_pst_b", 32'(pst_b), 0);
      check("rst_outs_a", 32'({imem_addr_a, alu_op_a, rd1_a, rd2_a, imm_a,
            imm_sel_a, wr_en_a, wr_addr_a, busy_a, done_a, flow_err_a, trap_a}), 0);
      check("rst_outs_b", 32'({imem_addr_b, alu_op_b, rd1_b, rd2_b, imm_b,
            imm_sel_b, wr_en_b, wr_addr_b, busy_b, done_b, flow_err_b, trap_b}), 0);
    end

    // start in the reset-release cycle is ignored.
    rst     = 1'b1;
    start_a = 1'b1;
    start_b = 1'b0;
    tick();
    start_a = 1'b0;
    check("start_at_release", 32'(pst_a), 0);

    // PROG_LEN=1, ADD r3 = r1 + r2.
    mem_a[0] = 16'hA312;
    start_a  = 1'b1;
    tick();
    start_a  = 1'b0;
    for (int i = 0; i < 7; i++) begin
      check($sformatf("add_pst_%0d", i), 32'(pst_a), 32'(exp_seq[i]));
      check($sformatf("add_op_%0d", i), 32'(alu_op_a), (i == 3) ? 32'hA : 32'h0);
      check($sformatf("add_wr_%0d", i), 32'(wr_en_a), (i == 4) ? 1 : 0);
      check($sformatf("add_done_%0d", i), 32'(done_a), (i == 5) ? 1 : 0);
      check($sformatf("add_busy_%0d", i), 32'(busy_a), (i < 5) ? 1 : 0);
      if (i == 3)
        check("add_dec", 32'({rd1_a, rd2_a, imm_a, imm_sel_a}), 32'({4'd1, 4'd2, 4'd2, 1'b0}));
      if (i == 4)
        check("add_wr_addr", 32'(wr_addr_a), 3);
      tick();
    end

    // ADDI with the ALU flagging a flow error in WB.
    mem_b[0] = 16'hC414;
    fc_en_b  = 1'b1;
    start_b  = 1'b1;
    tick();
    start_b  = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("ovf_in_wb", 32'(pst_b), 5);
    check("ovf_imm_sel", 32'(imm_sel_b), 1);
    check("ovf_wr_en", 32'(wr_en_b), 0);
    tick();
    fc_en_b = 1'b0;
    check("ovf_flow_err", 32'(flow_err_b), 1);
`ifdef FLOW_TRAP_EN
    check("ovf_trap_pst", 32'(pst_b), 7);
    check("ovf_trap", 32'(trap_b), 1);
    check("ovf_trap_pc", 32'(imem_addr_b), 0);
    check("ovf_trap_op", 32'(alu_op_b), 0);
    tick();
    check("ovf_trap_hold", 32'(pst_b), 7);
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    check("trap_restart_pst", 32'(pst_b), 1);
    check("trap_restart_ferr", 32'(flow_err_b), 0);
    exp_pc   = 4'd0;
    exp_ferr = 1'b0;
`else
    check("ovf_cont_pst", 32'(pst_b), 1);
    check("ovf_cont_trap", 32'(trap_b), 0);
    exp_pc   = 4'd1;
    exp_ferr = 1'b1;
`endif
    check("ovf_pc", 32'(imem_addr_b), 32'(exp_pc));

    // start during EXEC has no effect.
    for (int i = 0; i < 3; i++) tick();
    check("exec_before", 32'(pst_b), 4);
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    check("exec_start_pst", 32'(pst_b), 5);
    check("exec_start_pc", 32'(imem_addr_b), 32'(exp_pc));

    got_done = 1'b0;
    for (int c = 0; c < 200 && !got_done; c++) begin
      if (done_b) got_done = 1'b1;
      else tick();
    end
    check("ovf_run_done", 32'(got_done), 1);
    check("ovf_run_ferr", 32'(flow_err_b), 32'(exp_ferr));
    tick();
    check("ovf_run_idle", 32'(pst_b), 0);

    // PROG_LEN=16 of NOP / Read: no writes, pc 0..15, done at cycle 81.
    for (int i = 0; i < 16; i++)
      mem_b[i] = (i % 2 == 0) ? 16'h0000 : 16'h2010;
    start_b = 1'b1;
    tick();
    start_b  = 1'b0;
    idx      = 1;
    done_idx = -1;
    fetch_k  = 0;
    wr_seen  = 0;
    while (idx < 100 && done_idx < 0) begin
      if (wr_en_b) wr_seen++;
      if (pst_b == 3'b001) begin
        check($sformatf("nop_pc_%0d", fetch_k), 32'(imem_addr_b), 32'(fetch_k));
        fetch_k++;
      end
      if (done_b) done_idx = idx;
      else begin
        tick();
        idx++;
      end
    end
    check("nop_done_cycle", 32'(done_idx), 81);
    check("nop_fetches", 32'(fetch_k), 16);
    check("nop_no_write", 32'(wr_seen), 0);
    check("nop_ferr_clear", 32'(flow_err_b), 0);
    tick();

    // Reset during EXEC of pc=7, then restart from pc=0.
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    idx     = 0;
    while (idx < 100 && !(pst_b == 3'b100 && imem_addr_b == 4'd7)) begin
      tick();
      idx++;
    end
    check("rst7_reached", 32'({pst_b, imem_addr_b}), 32'({3'b100, 4'd7}));
    rst = 1'b0;
    #1;
    check("rst7_pst_now", 32'(pst_b), 0);
    check("rst7_wr_now", 32'(wr_en_b), 0);
    tick();
    check("rst7_wr_next", 32'(wr_en_b), 0);
    check("rst7_pc", 32'(imem_addr_b), 0);
    rst = 1'b1;
    tick();
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    check("rst7_restart_pst", 32'(pst_b), 1);
    check("rst7_restart_pc", 32'(imem_addr_b), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
